// File: rtl/array_feeder_pkg.sv
// Shared definitions for the systolic array feeder: data width,
// default array geometry and the feeder FSM state encoding.
package accel_pkg;

    localparam int DATA_W   = 8;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WFILL,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/array_feeder_if.sv
// Feeder bus: weight and activation streams in, north lanes out.
// master = producer/observer side, slave = array_feeder side.
interface array_feeder_if
    import accel_pkg::*;
#(
    parameter int COLS = DEF_COLS
);
    logic                     wt_valid;
    logic [COLS*DATA_W-1:0]   wt_data;
    logic                     wt_ready;
    logic                     act_valid;
    logic [COLS*DATA_W-1:0]   act_data;
    logic                     act_last;
    logic                     act_ready;
    logic                     load_weight;
    logic [COLS*DATA_W-1:0]   north_data;
    logic [COLS-1:0]          north_vld;
    logic                     busy;

    modport master (
        output wt_valid, wt_data, act_valid, act_data, act_last,
        input  wt_ready, act_ready, load_weight,
        input  north_data, north_vld, busy
    );

    modport slave (
        input  wt_valid, wt_data, act_valid, act_data, act_last,
        output wt_ready, act_ready, load_weight,
        output north_data, north_vld, busy
    );
endinterface

// File: rtl/array_feeder_skew_line.sv
// DEPTH-stage shift register carrying {vld, data} for one column.
// Ports: clk, rst (async high), i_d in, o_d out (DEPTH cycles later).
module skew_line
    import accel_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W:0]   i_d,
    output logic [DATA_W:0]   o_d
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_d = i_d;
        end else begin : g_shift
            logic [DATA_W:0] r_sh [DEPTH];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++)
                        r_sh[i] <= '0;
                end else begin
                    r_sh[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++)
                        r_sh[i] <= r_sh[i-1];
                end
            end
            assign o_d = r_sh[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/array_feeder.sv
// Feeds a weight-stationary array: buffers ROWS weight rows, loads them
// unskewed, then streams activations through per-column skew lines.
// Ports: clk, rst (async high), bus (array_feeder_if.slave).
module array_feeder
    import accel_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic           clk,
    input  logic           rst,
    array_feeder_if.slave  bus
);
    localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
    localparam int CNT_W = (MAXRC > 1) ? $clog2(MAXRC) : 1;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int VW    = COLS * DATA_W;

    state_t              r_state;
    state_t              w_nstate;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_cnt_en;
    logic [VW-1:0]       r_buf [ROWS];
    logic [VW-1:0]       r_com;
    logic                r_cvld;
    logic [VW-1:0]       w_first;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_nidx;
    logic                w_row_last;
    logic                w_col_last;
    logic                w_wt_ready;
    logic                w_act_ready;
    logic                w_load;
    logic                w_busy;
    logic                w_wt_hs;
    logic                w_act_hs;
    logic [DATA_W:0]     w_sk [COLS];

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_idx      = r_cnt[IDX_W-1:0];
    assign w_nidx     = w_cnt_inc[IDX_W-1:0];
    assign w_row_last = (r_cnt == CNT_W'(ROWS - 1));
    assign w_col_last = (r_cnt == CNT_W'(COLS - 1));
    assign w_wt_hs    = bus.wt_valid & w_wt_ready;
    assign w_act_hs   = bus.act_valid & w_act_ready;
    // Row 0 is already buffered when the last beat lands, unless ROWS==1.
    assign w_first    = (ROWS == 1) ? bus.wt_data : r_buf[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_nstate != r_state)
                r_cnt <= '0;
            else if (w_cnt_en)
                r_cnt <= w_cnt_inc;
        end
    end

    always_comb begin
        w_nstate    = r_state;
        w_cnt_en    = 1'b0;
        w_wt_ready  = 1'b0;
        w_act_ready = 1'b0;
        w_load      = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_busy   = 1'b0;
                w_nstate = ST_WFILL;
            end
            ST_WFILL: begin
                w_wt_ready = 1'b1;
                if (bus.wt_valid) begin
                    w_cnt_en = 1'b1;
                    if (w_row_last)
                        w_nstate = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load   = 1'b1;
                w_cnt_en = 1'b1;
                if (w_row_last)
                    w_nstate = ST_STREAM;
            end
            ST_STREAM: begin
                w_act_ready = 1'b1;
                if (bus.act_valid && bus.act_last)
                    w_nstate = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_cnt_en = 1'b1;
                if (w_col_last)
                    w_nstate = ST_IDLE;
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    // r_com is the common output register; it holds the next weight row
    // during LOAD and the accepted activation (or a bubble) otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                r_buf[i] <= '0;
            r_com  <= '0;
            r_cvld <= 1'b0;
        end else begin
            r_com  <= '0;
            r_cvld <= 1'b0;
            unique case (r_state)
                ST_WFILL: begin
                    if (w_wt_hs) begin
                        r_buf[w_idx] <= bus.wt_data;
                        if (w_row_last)
                            r_com <= w_first;
                    end
                end
                ST_LOAD: begin
                    if (!w_row_last)
                        r_com <= r_buf[w_nidx];
                end
                ST_STREAM: begin
                    if (w_act_hs) begin
                        r_com  <= bus.act_data;
                        r_cvld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weights never enter the skew lines: lanes are zeroed unless tagged.
    genvar c;
    generate
        for (c = 0; c < COLS; c++) begin : g_col
            logic [DATA_W-1:0] w_lane;
            assign w_lane = r_cvld ? r_com[c*DATA_W +: DATA_W] : '0;
            skew_line #(
                .DEPTH (c)
            ) u_skew (
                .clk (clk),
                .rst (rst),
                .i_d ({r_cvld, w_lane}),
                .o_d (w_sk[c])
            );
            assign bus.north_data[c*DATA_W +: DATA_W] =
                w_load ? r_com[c*DATA_W +: DATA_W]
                       : w_sk[c][DATA_W-1:0];
            assign bus.north_vld[c] = w_sk[c][DATA_W];
        end
    endgenerate

    assign bus.wt_ready    = w_wt_ready;
    assign bus.act_ready   = w_act_ready;
    assign bus.load_weight = w_load;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder: a cycle table for one full job
// plus hand sequences for gaps, bubbles, mid-stream reset, back-to-back.
module tb_array_feeder;
    import accel_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    array_feeder_if #(.COLS(4)) bus ();

    array_feeder #(
        .ROWS (4),
        .COLS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        av;
        logic [31:0] ad;
        logic        al;
        logic        e_wr;
        logic        e_ar;
        logic        e_ld;
        logic [31:0] e_nd;
        logic [3:0]  e_nv;
        logic        e_bz;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        logic wv, logic [31:0] wd, logic av, logic [31:0] ad, logic al,
        logic e_wr, logic e_ar, logic e_ld, logic [31:0] e_nd,
        logic [3:0] e_nv, logic e_bz);
        vec_t v;
        v.wv = wv; v.wd = wd; v.av = av; v.ad = ad; v.al = al;
        v.e_wr = e_wr; v.e_ar = e_ar; v.e_ld = e_ld;
        v.e_nd = e_nd; v.e_nv = e_nv; v.e_bz = e_bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic wr, input logic ar,
                           input logic ld, input logic [31:0] nd,
                           input logic [3:0] nv, input logic bz);
        chk({t, " wt_ready"}, 32'(bus.wt_ready), 32'(wr));
        chk({t, " act_ready"}, 32'(bus.act_ready), 32'(ar));
        chk({t, " load_weight"}, 32'(bus.load_weight), 32'(ld));
        chk({t, " north_data"}, bus.north_data, nd);
        chk({t, " north_vld"}, 32'(bus.north_vld), 32'(nv));
        chk({t, " busy"}, 32'(bus.busy), 32'(bz));
    endtask

    task automatic idle_inputs();
        bus.wt_valid  = 1'b0;
        bus.wt_data   = '0;
        bus.act_valid = 1'b0;
        bus.act_data  = '0;
        bus.act_last  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One beat per ready cycle, with gap idle cycles between beats.
    // Returns at the negedge of the first LOAD cycle.
    task automatic feed_wt(input logic [127:0] rows, input int gap);
        for (int k = 0; k < 4; k++) begin
            int guard;
            guard = 0;
            while (!bus.wt_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            chk("wt_ready wait", 32'(bus.wt_ready), 32'd1);
            bus.wt_valid = 1'b1;
            bus.wt_data  = rows[k*32 +: 32];
            @(negedge clk);
            bus.wt_valid = 1'b0;
            bus.wt_data  = '0;
            if (k < 3)
                repeat (gap) @(negedge clk);
        end
    endtask

    // Returns at the negedge of the first STREAM cycle.
    task automatic check_load(input string t, input logic [127:0] rows);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s load%0d flag", t, k),
                32'(bus.load_weight), 32'd1);
            chk($sformatf("%s load%0d data", t, k),
                bus.north_data, rows[k*32 +: 32]);
            @(negedge clk);
        end
        chk({t, " load end"}, 32'(bus.load_weight), 32'd0);
        chk({t, " stream ready"}, 32'(bus.act_ready), 32'd1);
    endtask

    localparam logic [127:0] W_A =
        {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    localparam logic [127:0] W_B =
        {32'hF0E0D0C0, 32'h7F80FF01, 32'h33221100, 32'hA5B6C7D8};
    localparam logic [127:0] W_C =
        {32'h44444444, 32'h33333333, 32'h22222222, 32'h9A9B9C9D};

    initial begin
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_nd;
        logic [3:0]  exp_nv;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h04030201, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[2]  = mk(1, 32'h08070605, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 32'h0C0B0A09, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 32'h100F0E0D, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h04030201, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h08070605, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0C0B0A09, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100F0E0D, 0, 1);
        tbl[9]  = mk(0, 0, 1, 32'h04FD02FF, 1, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h000000FF, 4'h1, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00000200, 4'h2, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00FD0000, 4'h4, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h04000000, 4'h8, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

        @(negedge clk);
        #1;
        chk_all("in reset", 0, 0, 0, 0, 0, 0);

        // Full job, cycle by cycle from reset release.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.wt_valid  = tbl[i].wv;
            bus.wt_data   = tbl[i].wd;
            bus.act_valid = tbl[i].av;
            bus.act_data  = tbl[i].ad;
            bus.act_last  = tbl[i].al;
            #1;
            chk_all($sformatf("tbl%0d", i), tbl[i].e_wr, tbl[i].e_ar,
                    tbl[i].e_ld, tbl[i].e_nd, tbl[i].e_nv, tbl[i].e_bz);
            @(negedge clk);
        end
        idle_inputs();

        // Gapped weight beats, then act_valid 1,0,1 with a bubble.
        do_reset();
        feed_wt(W_B, 3);
        check_load("gap", W_B);
        va = 32'hAA557F81;
        vb = 32'h3C80FE01;
        bus.act_valid = 1'b1;
        bus.act_data  = va;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            bus.act_valid = (j == 1);
            bus.act_data  = (j == 1) ? vb : '0;
            bus.act_last  = (j == 1);
            exp_nd = '0;
            exp_nv = '0;
            for (int c = 0; c < 4; c++) begin
                if (j == c) begin
                    exp_nd[c*8 +: 8] = va[c*8 +: 8];
                    exp_nv[c] = 1'b1;
                end else if (j == c + 2) begin
                    exp_nd[c*8 +: 8] = vb[c*8 +: 8];
                    exp_nv[c] = 1'b1;
                end
            end
            #1;
            chk_all($sformatf("bub%0d", j), 0, (j <= 1), 0,
                    exp_nd, exp_nv, 1);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("bub idle busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Reset with two beats in flight.
        do_reset();
        feed_wt(W_A, 0);
        check_load("rst", W_A);
        bus.act_valid = 1'b1;
        bus.act_data  = 32'h11223344;
        @(negedge clk);
        bus.act_data  = 32'h55667788;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("inflight vld", 32'(bus.north_vld), 32'h3);
        chk("inflight data", bus.north_data, 32'h00003388);
        rst = 1'b1;
        #1;
        chk_all("mid rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("post rst idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_all($sformatf("post rst%0d", i), 1, 0, 0, 0, 0, 1);
            @(negedge clk);
        end

        // Next job's weights offered during DRAIN.
        do_reset();
        feed_wt(W_A, 0);
        check_load("b2b", W_A);
        bus.act_valid = 1'b1;
        bus.act_data  = 32'h01020304;
        bus.act_last  = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus.wt_valid = 1'b1;
        bus.wt_data  = W_C[31:0];
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("b2b hold%0d wt_ready", i),
                32'(bus.wt_ready), 32'd0);
            chk($sformatf("b2b hold%0d busy", i),
                32'(bus.busy), 32'(i < 4));
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            bus.wt_data = W_C[k*32 +: 32];
            #1;
            chk($sformatf("b2b fill%0d wt_ready", k),
                32'(bus.wt_ready), 32'd1);
            @(negedge clk);
        end
        idle_inputs();
        check_load("b2b2", W_C);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/array_feeder.md
ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 Parameter ROWS, default 4, PE rows in the weight-stationary array.
REQ-002 Parameter COLS, default 4, PE columns; one 8-bit north lane per column.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wt_valid  in  1  weight beat offered.
REQ-006 wt_data  in  COLS*8  one weight row, signed, lane c in bits [8c+7:8c].
REQ-007 wt_ready  out  1  weight beat accepted when wt_valid && wt_ready.
REQ-008 act_valid  in  1  activation beat offered.
REQ-009 act_data  in  COLS*8  one activation vector, signed, lane c per REQ-006 layout.
REQ-010 act_last  in  1  marks final activation beat of the job.
REQ-011 act_ready  out  1  activation beat accepted when act_valid && act_ready.
REQ-012 load_weight  out  1  broadcast to every PE; high = weight-load cycle.
REQ-013 north_data  out  COLS*8  top-row PE north inputs, registered.
REQ-014 north_vld  out  COLS  per-column tag: lane carries a real activation.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, WFILL, LOAD, STREAM, DRAIN.
REQ-017 IDLE -> WFILL unconditionally on next cycle; IDLE exists only for one cycle after reset/job end.
REQ-018 WFILL: wt_ready=1; accepted beats stored in ROWS-entry buffer, index k = k-th accepted beat; after ROWS-th accept -> LOAD.
REQ-019 LOAD: exactly ROWS consecutive cycles, load_weight=1, north_data = buffer entry k on cycle k (k=0..ROWS-1), no gaps, no skew; so beat k settles in PE row ROWS-1-k.
REQ-020 LOAD -> STREAM after ROWS-th load cycle; load_weight=0 in all other states.
REQ-021 STREAM: act_ready=1; accepted beat at edge t drives column c lane and north_vld[c]=1 at edge t+1+c.
REQ-022 STREAM, no beat accepted in a cycle: zero vector with north_vld=0 enters the skew lines (bubble); ordering of real beats preserved.
REQ-023 Beat accepted with act_last=1 -> DRAIN; act_ready=0 from next cycle.
REQ-024 DRAIN: zeros with vld=0 injected for COLS cycles until all skew lines flushed, then -> IDLE.
REQ-025 wt_ready=0 and act_ready=0 outside WFILL and STREAM respectively; beats offered then are not accepted.
REQ-026 Skew line for column c: c-stage delay after one common output register; column 0 has no extra delay.
REQ-027 Data passed bit-exact; no arithmetic, no sign change, lanes never reordered.
REQ-028 busy falls on the cycle the FSM enters IDLE.

Reset
REQ-029 rst asserted (any state, any cycle): state=IDLE, weight buffer and counters cleared, all skew stages 0.
REQ-030 Reset outputs: wt_ready=0, act_ready=0, load_weight=0, north_data=0, north_vld=0, busy=0.
REQ-031 Reset mid-LOAD or mid-STREAM abandons the job; no partial load or activation emitted after release.

Structure
REQ-032 Shared package accel_pkg holds DATA_W=8, default ROWS/COLS, and the FSM state enum.
REQ-033 One sub-module skew_line (parameter DEPTH, width DATA_W+1 data+vld shift register, async reset), instantiated once per column.

Verification
REQ-034 Reset mid-STREAM with 2 beats in flight -> all outputs 0 next cycle, FSM in IDLE, no stale lane after release.
REQ-035 Weights rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> load_weight high 4 consecutive cycles, north_data lane0 = 1,5,9,13.
REQ-036 Weight beats with wt_valid gaps of 3 cycles -> LOAD still 4 contiguous cycles with identical data order.
REQ-037 Single activation {-1,2,-3,4} with last -> lane c = value at t+1+c, north_vld one-hot per column, then DRAIN 4 cycles, busy low after.
REQ-038 act_valid toggling 1,0,1 -> bubble of zeros with north_vld=0 between beats in every column, beats at correct skew.
REQ-039 Back-to-back jobs: second job's weights offered during DRAIN -> wt_ready stays 0 until WFILL, no beat lost.
